// File: rtl/mips_stage_mem.sv
// Memory-access pipeline stage: registers the execute bundle into the Mem->Reg
// writeback bundle and performs loads/stores over a req/ack data-memory port.
module mips_stage_mem #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_instruction,
  input  logic [31:0] ex_pcAddr,
  input  logic [31:0] ex_aluResult,
  input  logic [31:0] ex_storeData,
  input  logic        ex_memRead,
  input  logic        ex_memWrite,
  input  logic [1:0]  ex_memSize,
  input  logic        ex_memSigned,
  input  logic        ex_regWrite,
  input  logic [4:0]  ex_writeReg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_instruction,
  output logic [31:0] mem_pcAddr,
  output logic [31:0] mem_memOut,
  output logic [31:0] mem_aluResult,
  output logic        mem_regWrite,
  output logic [4:0]  mem_writeReg,
  output logic        stall,
  output logic        fault
);

  // Handshake: a bundle is taken on a rising edge where ex_valid && ex_ready;
  // dmem_* stay stable from the request edge until the edge that samples dmem_ack.
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [7:0]  timer;
  logic        capIsLoad;
  logic [1:0]  capSize;
  logic        capSigned;
  logic        capRegWrite;

  logic        isMem;
  logic        isLoad;
  logic        misaligned;
  logic [3:0]  storeBe;
  logic [31:0] storeData;
  logic [31:0] byteShift;
  logic [31:0] halfShift;
  logic [31:0] loadData;

  assign ex_ready   = (state == IDLE);
  assign stall      = (state == BUSY);
  assign isMem      = ex_memRead | ex_memWrite;
  assign isLoad     = ex_memRead & ~ex_memWrite;
  assign misaligned = (ex_memSize == 2'd1 && ex_aluResult[0]) ||
                      (ex_memSize[1] && ex_aluResult[1:0] != 2'b00);

  always_comb begin
    storeBe   = 4'b1111;
    storeData = ex_storeData;
    case (ex_memSize)
      2'd0: begin
        storeBe   = 4'b0001 << ex_aluResult[1:0];
        storeData = {4{ex_storeData[7:0]}};
      end
      2'd1: begin
        storeBe   = 4'b0011 << {ex_aluResult[1], 1'b0};
        storeData = {2{ex_storeData[15:0]}};
      end
      default: begin
        storeBe   = 4'b1111;
        storeData = ex_storeData;
      end
    endcase
  end

  // mem_aluResult already holds the captured address while BUSY.
  assign byteShift = dmem_rdata >> {mem_aluResult[1:0], 3'b000};
  assign halfShift = dmem_rdata >> {mem_aluResult[1], 4'b0000};

  always_comb begin
    loadData = dmem_rdata;
    case (capSize)
      2'd0: loadData = capSigned ? {{24{byteShift[7]}}, byteShift[7:0]}
                                 : {24'd0, byteShift[7:0]};
      2'd1: loadData = capSigned ? {{16{halfShift[15]}}, halfShift[15:0]}
                                 : {16'd0, halfShift[15:0]};
      default: loadData = dmem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= IDLE;
      timer           <= 8'd0;
      capIsLoad       <= 1'b0;
      capSize         <= 2'd0;
      capSigned       <= 1'b0;
      capRegWrite     <= 1'b0;
      dmem_req        <= 1'b0;
      dmem_we         <= 1'b0;
      dmem_addr       <= 32'd0;
      dmem_wdata      <= 32'd0;
      dmem_be         <= 4'd0;
      mem_valid       <= 1'b0;
      mem_instruction <= 32'd0;
      mem_pcAddr      <= 32'd0;
      mem_memOut      <= 32'd0;
      mem_aluResult   <= 32'd0;
      mem_regWrite    <= 1'b0;
      mem_writeReg    <= 5'd0;
      fault           <= 1'b0;
    end else begin
      mem_valid <= 1'b0;
      fault     <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            mem_instruction <= ex_instruction;
            mem_pcAddr      <= ex_pcAddr;
            mem_aluResult   <= ex_aluResult;
            mem_writeReg    <= ex_writeReg;
            mem_memOut      <= 32'd0;
            if (!isMem) begin
              mem_valid    <= 1'b1;
              mem_regWrite <= ex_regWrite;
            end else if (misaligned) begin
              mem_valid    <= 1'b1;
              mem_regWrite <= 1'b0;
              fault        <= 1'b1;
            end else begin
              mem_regWrite <= 1'b0;
              capRegWrite  <= ex_regWrite;
              capIsLoad    <= isLoad;
              capSize      <= ex_memSize;
              capSigned    <= ex_memSigned;
              dmem_req     <= 1'b1;
              dmem_we      <= ex_memWrite;
              dmem_addr    <= {ex_aluResult[31:2], 2'b00};
              dmem_be      <= isLoad ? 4'b1111 : storeBe;
              dmem_wdata   <= isLoad ? 32'd0 : storeData;
              timer        <= 8'd0;
              state        <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state        <= IDLE;
            dmem_req     <= 1'b0;
            mem_valid    <= 1'b1;
            mem_memOut   <= capIsLoad ? loadData : 32'd0;
            mem_regWrite <= capRegWrite;
          end else if (timer == 8'(TIMEOUT - 1)) begin
            // Request has been up for TIMEOUT cycles with no ack: abort.
            state        <= IDLE;
            dmem_req     <= 1'b0;
            mem_valid    <= 1'b1;
            mem_regWrite <= 1'b0;
            fault        <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_stage_mem.sv
// Directed bench for mips_stage_mem: ALU pass-through, loads/stores, faults,
// timeout (second instance with TIMEOUT=4) and reset during an access.
module tb_mips_stage_mem;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_valid4 = 1'b0;
  logic [31:0] ex_instruction = 32'd0;
  logic [31:0] ex_pcAddr = 32'd0;
  logic [31:0] ex_aluResult = 32'd0;
  logic [31:0] ex_storeData = 32'd0;
  logic        ex_memRead = 1'b0;
  logic        ex_memWrite = 1'b0;
  logic [1:0]  ex_memSize = 2'd0;
  logic        ex_memSigned = 1'b0;
  logic        ex_regWrite = 1'b0;
  logic [4:0]  ex_writeReg = 5'd0;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        ack4 = 1'b0;

  logic        ex_ready, dmem_req, dmem_we, mem_valid, mem_regWrite, stall, fault;
  logic [31:0] dmem_addr, dmem_wdata, mem_instruction, mem_pcAddr, mem_memOut, mem_aluResult;
  logic [3:0]  dmem_be;
  logic [4:0]  mem_writeReg;

  logic        ready4, req4, we4, valid4, regWrite4, stall4, fault4;
  logic [31:0] addr4, wdata4, instr4, pc4, memOut4, alu4;
  logic [3:0]  be4;
  logic [4:0]  writeReg4;

  int checkCount = 0;
  int passCount  = 0;
  logic [31:0] exp_q[$];

  mips_stage_mem dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_instruction(ex_instruction), .ex_pcAddr(ex_pcAddr), .ex_aluResult(ex_aluResult),
    .ex_storeData(ex_storeData), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_memSize(ex_memSize), .ex_memSigned(ex_memSigned), .ex_regWrite(ex_regWrite),
    .ex_writeReg(ex_writeReg), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_valid(mem_valid),
    .mem_instruction(mem_instruction), .mem_pcAddr(mem_pcAddr), .mem_memOut(mem_memOut),
    .mem_aluResult(mem_aluResult), .mem_regWrite(mem_regWrite), .mem_writeReg(mem_writeReg),
    .stall(stall), .fault(fault)
  );

  mips_stage_mem #(.TIMEOUT(4)) dut4 (
    .clock(clock), .reset(reset), .ex_valid(ex_valid4), .ex_ready(ready4),
    .ex_instruction(ex_instruction), .ex_pcAddr(ex_pcAddr), .ex_aluResult(ex_aluResult),
    .ex_storeData(ex_storeData), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_memSize(ex_memSize), .ex_memSigned(ex_memSigned), .ex_regWrite(ex_regWrite),
    .ex_writeReg(ex_writeReg), .dmem_req(req4), .dmem_we(we4),
    .dmem_addr(addr4), .dmem_wdata(wdata4), .dmem_be(be4),
    .dmem_ack(ack4), .dmem_rdata(dmem_rdata), .mem_valid(valid4),
    .mem_instruction(instr4), .mem_pcAddr(pc4), .mem_memOut(memOut4),
    .mem_aluResult(alu4), .mem_regWrite(regWrite4), .mem_writeReg(writeReg4),
    .stall(stall4), .fault(fault4)
  );

  // Clock and reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Driver tasks
  task automatic setEx(input logic [31:0] alu, input logic [31:0] sdata, input logic rd,
                       input logic wr, input logic [1:0] size, input logic sgn,
                       input logic regW, input logic [4:0] wReg);
    ex_valid       = 1'b1;
    ex_instruction = {16'h1234, alu[15:0]};
    ex_pcAddr      = 32'h0040_0000 + alu;
    ex_aluResult   = alu;
    ex_storeData   = sdata;
    ex_memRead     = rd;
    ex_memWrite    = wr;
    ex_memSize     = size;
    ex_memSigned   = sgn;
    ex_regWrite    = regW;
    ex_writeReg    = wReg;
  endtask

  task automatic clearEx;
    ex_valid    = 1'b0;
    ex_memRead  = 1'b0;
    ex_memWrite = 1'b0;
  endtask

  task automatic memOp(input string tag, input logic [31:0] alu, input logic [31:0] sdata,
                       input logic rd, input logic wr, input logic [1:0] size,
                       input logic sgn, input logic regW, input logic [3:0] expBe,
                       input logic [31:0] expWdata, input logic [31:0] rdata,
                       input logic [31:0] expOut, input int ackDelay);
    logic [31:0] alignedAddr;
    alignedAddr = {alu[31:2], 2'b00};
    setEx(alu, sdata, rd, wr, size, sgn, regW, 5'd7);
    exp_q.push_back(expOut);
    tick;
    clearEx;
    check({tag, "_req"}, 32'(dmem_req), 32'd1);
    check({tag, "_we"}, 32'(dmem_we), 32'(wr));
    check({tag, "_addr"}, dmem_addr, alignedAddr);
    check({tag, "_be"}, 32'(dmem_be), 32'(expBe));
    if (wr) check({tag, "_wdata"}, dmem_wdata, expWdata);
    check({tag, "_ready"}, 32'(ex_ready), 32'd0);
    check({tag, "_validBusy"}, 32'(mem_valid), 32'd0);
    check({tag, "_stall"}, 32'(stall), 32'd1);
    for (int i = 0; i < ackDelay; i++) begin
      tick;
      check({tag, "_stallWait"}, 32'(stall), 32'd1);
      check({tag, "_reqHeld"}, 32'(dmem_req), 32'd1);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    tick;
    dmem_ack = 1'b0;
    check({tag, "_stallDone"}, 32'(stall), 32'd0);
    check({tag, "_reqDone"}, 32'(dmem_req), 32'd0);
    check({tag, "_valid"}, 32'(mem_valid), 32'd1);
    check({tag, "_memOut"}, mem_memOut, expOut);
    check({tag, "_regWrite"}, 32'(mem_regWrite), 32'(regW));
    check({tag, "_writeReg"}, 32'(mem_writeReg), 32'd7);
  endtask

  // Scoreboard: every writeback on the main instance must match the queue head
  always @(posedge clock) begin
    #2;
    if (reset && mem_valid) begin
      if (exp_q.size() == 0) check("sb_unexpectedValid", 32'd1, 32'd0);
      else check("sb_memOut", mem_memOut, exp_q.pop_front());
    end
  end

  initial begin
    repeat (2) tick;
    check("rst_valid", 32'(mem_valid), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_ready", 32'(ex_ready), 32'd1);
    reset = 1'b1;
    tick;

    // Back-to-back ALU ops
    setEx(32'h10, 32'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd8);
    exp_q.push_back(32'd0);
    tick;
    check("alu0_valid", 32'(mem_valid), 32'd1);
    check("alu0_alu", mem_aluResult, 32'h10);
    check("alu0_wreg", 32'(mem_writeReg), 32'd8);
    check("alu0_regWrite", 32'(mem_regWrite), 32'd1);
    check("alu0_instr", mem_instruction, 32'h1234_0010);
    check("alu0_pc", mem_pcAddr, 32'h0040_0010);
    check("alu0_stall", 32'(stall), 32'd0);
    setEx(32'h20, 32'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd9);
    exp_q.push_back(32'd0);
    tick;
    clearEx;
    check("alu1_valid", 32'(mem_valid), 32'd1);
    check("alu1_alu", mem_aluResult, 32'h20);
    check("alu1_wreg", 32'(mem_writeReg), 32'd9);
    check("alu1_stall", 32'(stall), 32'd0);
    tick;
    check("alu_idleValid", 32'(mem_valid), 32'd0);

    // Loads and stores: tag, addr, sdata, rd, wr, size, sgn, regW, be, wdata, rdata, out, delay
    memOp("lw104", 32'h104, 32'd0, 1, 0, 2'd2, 0, 1, 4'b1111, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF, 3);
    memOp("lbS203", 32'h203, 32'd0, 1, 0, 2'd0, 1, 1, 4'b1111, 32'd0, 32'h80112233, 32'hFFFFFF80, 1);
    memOp("lbU203", 32'h203, 32'd0, 1, 0, 2'd0, 0, 1, 4'b1111, 32'd0, 32'h80112233, 32'h00000080, 0);
    memOp("lhU202", 32'h202, 32'd0, 1, 0, 2'd1, 0, 1, 4'b1111, 32'd0, 32'h80112233, 32'h00008011, 0);
    memOp("lhS200", 32'h200, 32'd0, 1, 0, 2'd1, 1, 1, 4'b1111, 32'd0, 32'h80118233, 32'hFFFF8233, 0);
    memOp("sh302", 32'h302, 32'h0000ABCD, 0, 1, 2'd1, 0, 0, 4'b1100, 32'hABCDABCD, 32'h11111111, 32'd0, 1);
    memOp("sb301", 32'h301, 32'h1234565A, 0, 1, 2'd0, 0, 0, 4'b0010, 32'h5A5A5A5A, 32'h0, 32'd0, 0);
    memOp("rdwr", 32'h308, 32'hCAFE1234, 1, 1, 2'd3, 0, 0, 4'b1111, 32'hCAFE1234, 32'h77777777, 32'd0, 0);

    // Misaligned word load: fault bubble, no request
    setEx(32'h101, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd4);
    exp_q.push_back(32'd0);
    tick;
    clearEx;
    check("mis_req", 32'(dmem_req), 32'd0);
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_valid", 32'(mem_valid), 32'd1);
    check("mis_regWrite", 32'(mem_regWrite), 32'd0);
    check("mis_instr", mem_instruction, 32'h1234_0101);
    check("mis_stall", 32'(stall), 32'd0);
    tick;
    check("mis_faultPulse", 32'(fault), 32'd0);
    check("mis_validPulse", 32'(mem_valid), 32'd0);

    // Timeout on the TIMEOUT=4 instance, ack never asserted
    setEx(32'h400, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd5);
    ex_valid  = 1'b0;
    ex_valid4 = 1'b1;
    tick;
    ex_valid4 = 1'b0;
    clearEx;
    check("to_req0", 32'(req4), 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick;
      check("to_reqHeld", 32'(req4), 32'd1);
      check("to_noFault", 32'(fault4), 32'd0);
    end
    tick;
    check("to_reqDrop", 32'(req4), 32'd0);
    check("to_fault", 32'(fault4), 32'd1);
    check("to_valid", 32'(valid4), 32'd1);
    check("to_regWrite", 32'(regWrite4), 32'd0);
    check("to_idle", 32'(ready4), 32'd1);
    tick;
    check("to_faultPulse", 32'(fault4), 32'd0);

    // Reset in the middle of an access, then a late ack
    setEx(32'h500, 32'd0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd6);
    tick;
    clearEx;
    check("rb_req", 32'(dmem_req), 32'd1);
    tick;
    reset = 1'b0;
    tick;
    check("rb_req0", 32'(dmem_req), 32'd0);
    check("rb_stall", 32'(stall), 32'd0);
    check("rb_be", 32'(dmem_be), 32'd0);
    check("rb_addr", dmem_addr, 32'd0);
    check("rb_valid", 32'(mem_valid), 32'd0);
    reset      = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    tick;
    dmem_ack = 1'b0;
    check("rb_lateAckValid", 32'(mem_valid), 32'd0);
    check("rb_lateAckOut", mem_memOut, 32'd0);
    memOp("lw600", 32'h600, 32'd0, 1, 0, 2'd2, 0, 1, 4'b1111, 32'd0, 32'h12345678, 32'h12345678, 2);

    repeat (3) tick;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mips_stage_mem.md
Name: mips_stage_mem

Overview:
- Memory-access pipeline stage.
- Accepts one instruction per cycle from the execute stage and performs loads and stores over a req/ack data-memory handshake.
- Produces the registered Mem→Reg writeback bundle (instruction, pcAddr, memOut, aluResult, write port) that the register stage consumes as its write-back input.
- Raises a stall to the hazard unit while a memory access is outstanding.

Parameters:
- TIMEOUT, 16: cycles dmem_req may wait for dmem_ack before the access is aborted with a fault; legal range 1..255.

Ports:
- clock  input  1  stage clock
- reset  input  1  synchronous, active-low reset (`reset`=0 resets on the rising edge of `clock`)
- ex_valid  input  1  execute-stage bundle valid
- ex_ready  output  1  stage can accept the bundle this cycle
- ex_instruction  input  32  instruction word
- ex_pcAddr  input  32  instruction PC
- ex_aluResult  input  32  ALU result / effective address
- ex_storeData  input  32  store source register value
- ex_memRead  input  1  load
- ex_memWrite  input  1  store
- ex_memSize  input  2  0=byte, 1=half, 2=word; 3 is treated as word
- ex_memSigned  input  1  sign-extend a load
- ex_regWrite  input  1  instruction writes a register
- ex_writeReg  input  5  destination register
- dmem_req  output  1  access request
- dmem_we  output  1  write enable
- dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  output  32  write data
- dmem_be  output  4  byte enables
- dmem_ack  input  1  access complete; dmem_rdata is valid in the same cycle
- dmem_rdata  input  32  read data
- mem_valid  output  1  writeback bundle valid
- mem_instruction  output  32  bundle instruction
- mem_pcAddr  output  32  bundle PC
- mem_memOut  output  32  formatted load data
- mem_aluResult  output  32  passed-through ALU result
- mem_regWrite  output  1  write enable for the register stage
- mem_writeReg  output  5  destination register
- stall  output  1  memory access outstanding
- fault  output  1  one-cycle pulse on a misaligned access or a timeout

Behaviour:
- Reset: state IDLE; all mem_* outputs 0; dmem_req, dmem_we and dmem_be 0; dmem_addr and dmem_wdata 0; stall 0; fault 0; timeout counter 0.
- Reset during BUSY drops dmem_req on the next edge. A dmem_ack that arrives after this is ignored.
- ex_ready = (state==IDLE).
- stall = (state==BUSY).
- States: IDLE and BUSY.
- IDLE, ex_valid and no memory operation: the bundle is registered into mem_* and mem_valid=1 on the next cycle. Latency is 1 cycle, throughput 1 per cycle.
- IDLE, ex_valid and no memory operation, memOut: mem_memOut=0.
- IDLE, ex_valid with memRead or memWrite, access aligned: capture the bundle and drive dmem_* registered. Next cycle dmem_req=1 and state goes to BUSY. mem_valid=0 for that cycle.
- Alignment: half requires aluResult[0]=0; word requires aluResult[1:0]=0.
- Misaligned access: no request is issued. On the next cycle mem_valid=1 with mem_regWrite=0 (bubble that keeps the instruction) and fault=1 for 1 cycle.
- ex_memRead and ex_memWrite both set: treated as a store.
- BUSY: dmem_* are held stable until ack. The counter increments each cycle.
- BUSY, on dmem_ack: next cycle state=IDLE, dmem_req=0, mem_valid=1, mem_memOut = formatted rdata (0 for a store), and the captured regWrite is passed on.
- BUSY, counter reaches TIMEOUT before ack: abort. Next cycle dmem_req=0, IDLE, mem_valid=1, regWrite=0, fault=1.
- mem_valid is high for exactly one cycle per accepted instruction.
- Little-endian lanes, lane k = bits [8k+7:8k], with k=addr[1:0] for byte and addr[1]*2 for half.
- Store byte: be=0001<<k, wdata={4{data[7:0]}}.
- Store half: be=0011<<k, wdata={2{data[15:0]}}.
- Store word: be=1111, wdata=data.
- Load byte and half: extract the lane, then sign-extend or zero-extend per memSigned.
- Load word: rdata unchanged.
- Load requests drive dmem_we=0 and be=1111.

Test Plan:
- ALU op, aluResult=0x00000010, writeReg=8, regWrite=1 → next cycle mem_valid=1, mem_aluResult=0x10, mem_writeReg=8; back-to-back ops with no bubbles; stall=0 throughout.
- Word load at addr 0x104, ack 3 cycles after req, rdata=0xDEADBEEF → stall=1 for 4 cycles, dmem_addr=0x104, be=1111; mem_memOut=0xDEADBEEF one cycle after ack; ex_ready=0 while BUSY.
- Signed byte load at 0x203, rdata=0x80112233 → mem_memOut=0xFFFFFF80; unsigned gives 0x00000080; unsigned half load at 0x202 gives 0x00008011.
- Half store at 0x302, data=0x0000ABCD → dmem_we=1, be=1100, wdata=0xABCDABCD, dmem_addr=0x300; mem_regWrite=0 after ack.
- Word load at 0x101 → no dmem_req; fault=1 for 1 cycle; mem_valid=1 with regWrite=0. With TIMEOUT=4 and ack never asserted → req held 4 cycles, then fault=1 and IDLE.
- Reset=0 asserted mid-BUSY, then a late ack → all outputs 0 after the edge, no mem_valid produced; the next load completes normally.
